ntt_rom_sequencer: RTL and testbench

Reads the 128-entry NTT control ROM (two butterfly descriptors per 64-bit word: polynomial indices plus 12-bit twiddle) and turns it into a stream of single-butterfly commands for the butterfly datapath. It sits between the control ROM and the butterfly unit. It hides the ROM's one-cycle registered read latency and absorbs datapath back-pressure, so that with no stalls the stream sustains one butterfly per cycle.

---
 rtl/ntt_pkg.sv | 52 +++++
 rtl/ntt_word_buf.sv | 96 +++++++++
 rtl/ntt_rom_sequencer.sv | 136 +++++++++++++
 tb/tb_ntt_rom_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT control-ROM sequencer: sizes, ROM word
// layout, the butterfly command struct and the sequencer state encoding.
package ntt_pkg;

    localparam int Q         = 3329;
    localparam int ADDR_W    = 7;
    localparam int NUM_WORDS = 128;
    localparam int IDX_W     = 8;
    localparam int ZETA_W    = 12;
    localparam int WORD_W    = 64;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    // ROM word layout: two 32-bit halves, each {rsv[3:0], zeta, idx_a, idx_b}
    localparam int HI_LSB      = 32;
    localparam int RSV_W       = 4;
    localparam int RSV_HI_LSB  = 60;
    localparam int RSV_LO_LSB  = 28;

    // Field positions inside one half once the reserved nibble is removed
    localparam int HALF_W      = 28;
    localparam int PAYLOAD_W   = 2 * HALF_W;
    localparam int ZETA_LSB    = 16;
    localparam int IDXA_LSB    = 8;
    localparam int IDXB_LSB    = 0;

    typedef struct packed {
        logic [IDX_W-1:0]  idx_a;
        logic [IDX_W-1:0]  idx_b;
        logic [ZETA_W-1:0] zeta;
        logic              slot;
        logic              last;
    } bf_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } state_t;

    // True when either reserved nibble of a ROM word is nonzero
    function automatic logic reserved_bad(input logic [WORD_W-1:0] w);
        return (w[RSV_HI_LSB +: RSV_W] != '0) || (w[RSV_LO_LSB +: RSV_W] != '0);
    endfunction

    // Drops both reserved nibbles, leaving {hi_half, lo_half}
    function automatic logic [PAYLOAD_W-1:0] strip_payload(input logic [WORD_W-1:0] w);
        return {w[RSV_HI_LSB-1:HI_LSB], w[RSV_LO_LSB-1:0]};
    endfunction

endpackage

// File: rtl/ntt_word_buf.sv
// Two-entry ROM word buffer. The current word is issued as two butterfly
// commands (low half, then high half); the next word waits behind it so the
// command stream never bubbles. Also flags words with reserved bits set.
module ntt_word_buf
    import ntt_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_cur_i,
    input  logic              load_nxt_i,
    input  logic              load_last_i,
    input  logic [WORD_W-1:0] rom_word_i,
    input  logic              ready_i,
    output logic              cur_valid_o,
    output logic              nxt_valid_o,
    output logic              fire_o,
    output bf_cmd_t           cmd_o,
    output logic              fmt_err_o
);

    logic [PAYLOAD_W-1:0] cur_word_q;
    logic [PAYLOAD_W-1:0] nxt_word_q;
    logic                 cur_last_q;
    logic                 nxt_last_q;
    logic                 cur_valid_q;
    logic                 nxt_valid_q;
    logic                 slot_q;
    logic                 fmt_err_q;
    logic                 fire;
    logic [HALF_W-1:0]    half;

    assign fire        = cur_valid_q && ready_i;
    assign fire_o      = fire;
    assign cur_valid_o = cur_valid_q;
    assign nxt_valid_o = nxt_valid_q;
    assign fmt_err_o   = fmt_err_q;

    // Buffer state: load/advance the current word, refill the prefetch slot, track format errors
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_word_q  <= '0;
            nxt_word_q  <= '0;
            cur_last_q  <= 1'b0;
            nxt_last_q  <= 1'b0;
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
            slot_q      <= 1'b0;
            fmt_err_q   <= 1'b0;
        end else if (clear_i) begin
            cur_last_q  <= 1'b0;
            nxt_last_q  <= 1'b0;
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
            slot_q      <= 1'b0;
            fmt_err_q   <= 1'b0;
        end else begin
            if (load_cur_i) begin
                cur_word_q  <= strip_payload(rom_word_i);
                cur_last_q  <= load_last_i;
                cur_valid_q <= 1'b1;
                slot_q      <= 1'b0;
            end else if (fire) begin
                if (slot_q) begin
                    slot_q      <= 1'b0;
                    cur_word_q  <= nxt_word_q;
                    cur_last_q  <= nxt_last_q;
                    cur_valid_q <= nxt_valid_q;
                end else begin
                    slot_q <= 1'b1;
                end
            end
            if (load_nxt_i) begin
                nxt_word_q  <= strip_payload(rom_word_i);
                nxt_last_q  <= load_last_i;
                nxt_valid_q <= 1'b1;
            end else if (fire && slot_q) begin
                nxt_valid_q <= 1'b0;
            end
            if ((load_cur_i || load_nxt_i) && reserved_bad(rom_word_i)) begin
                fmt_err_q <= 1'b1;
            end
        end
    end

    // Select the half addressed by the slot pointer and unpack it into a command
    always_comb begin
        half        = slot_q ? cur_word_q[PAYLOAD_W-1:HALF_W] : cur_word_q[HALF_W-1:0];
        cmd_o.idx_a = half[IDXA_LSB +: IDX_W];
        cmd_o.idx_b = half[IDXB_LSB +: IDX_W];
        cmd_o.zeta  = half[ZETA_LSB +: ZETA_W];
        cmd_o.slot  = slot_q;
        cmd_o.last  = cur_valid_q && cur_last_q && slot_q;
    end

endmodule

// File: rtl/ntt_rom_sequencer.sv
// Walks the 128-word NTT control ROM once per start and streams single
// butterfly commands, hiding the ROM read latency and absorbing back-pressure.
module ntt_rom_sequencer
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fmt_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_dout,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [IDX_W-1:0]  bf_idx_a,
    output logic [IDX_W-1:0]  bf_idx_b,
    output logic [ZETA_W-1:0] bf_zeta,
    output logic              bf_slot,
    output logic              bf_last
);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              stable_q;
    logic              fill_wait_q;
    logic              fetch_done_q;

    logic              start_acc;
    logic              load_cur;
    logic              load_nxt;
    logic              at_last;
    logic              nxt_valid;
    logic              cur_valid;
    logic              fire;
    logic              last_fire;
    bf_cmd_t           cmd;

    // rom_dout reflects addr_q only once addr_q has held across one edge (stable_q)
    assign start_acc = (state_q == ST_IDLE) && start;
    assign load_cur  = (state_q == ST_FILL) && fill_wait_q;
    assign load_nxt  = (state_q == ST_RUN) && stable_q && !nxt_valid && !fetch_done_q;
    assign at_last   = (addr_q == LAST_ADDR);
    assign last_fire = fire && cmd.last;

    ntt_word_buf u_word_buf (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (start_acc),
        .load_cur_i  (load_cur),
        .load_nxt_i  (load_nxt),
        .load_last_i (load_nxt && at_last),
        .rom_word_i  (rom_dout),
        .ready_i     (bf_ready),
        .cur_valid_o (cur_valid),
        .nxt_valid_o (nxt_valid),
        .fire_o      (fire),
        .cmd_o       (cmd),
        .fmt_err_o   (fmt_err)
    );

    // Next ROM address: step once during fill, then after each prefetch capture, parked at 0 when idle
    always_comb begin
        addr_d = addr_q;
        case (state_q)
            ST_IDLE: addr_d = '0;
            ST_FILL: if (!fill_wait_q) addr_d = addr_q + 1'b1;
            ST_RUN:  if (load_nxt && !at_last) addr_d = addr_q + 1'b1;
            ST_DONE: addr_d = '0;
            default: addr_d = '0;
        endcase
    end

    // Sequencer FSM with registered busy/done and the ROM address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            stable_q     <= 1'b0;
            fill_wait_q  <= 1'b0;
            fetch_done_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            stable_q <= (addr_d == addr_q);
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q      <= ST_FILL;
                        busy_q       <= 1'b1;
                        fill_wait_q  <= 1'b0;
                        fetch_done_q <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (!fill_wait_q) begin
                        fill_wait_q <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load_nxt && at_last) begin
                        fetch_done_q <= 1'b1;
                    end
                    if (last_fire) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = addr_q;
    assign bf_valid = cur_valid;
    assign bf_idx_a = cmd.idx_a;
    assign bf_idx_b = cmd.idx_b;
    assign bf_zeta  = cmd.zeta;
    assign bf_slot  = cmd.slot;
    assign bf_last  = cmd.last;

endmodule

// File: tb/tb_ntt_rom_sequencer.sv
// Scoreboard bench for ntt_rom_sequencer: a ROM model feeds the DUT, each pass
// queues the 256 expected commands, and a negedge monitor checks every transfer.
module tb_ntt_rom_sequencer;
    import ntt_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              fmt_err;
    logic [ADDR_W-1:0] rom_addr;
    logic [63:0]       rom_dout = '0;
    logic              bf_valid;
    logic              bf_ready;
    logic [IDX_W-1:0]  bf_idx_a;
    logic [IDX_W-1:0]  bf_idx_b;
    logic [ZETA_W-1:0] bf_zeta;
    logic              bf_slot;
    logic              bf_last;

    logic [63:0] romMem [NUM_WORDS];
    logic [29:0] expQ [$];
    logic [29:0] heldCmd;
    logic [29:0] actCmd;
    logic [29:0] expCmd;
    logic        holdValid = 1'b0;
    logic        readyRandom = 1'b0;
    logic        passActive = 1'b0;
    logic        expFmt = 1'b0;
    logic        prevFmt = 1'b0;
    int          cycleCnt = 0;
    int          e0Edge = 0;
    int          rxCount = 0;
    int          passStalls = 0;
    int          lastFireEdge = -1;
    int          checks = 0;
    int          errors = 0;

    ntt_rom_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .fmt_err  (fmt_err),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .bf_valid (bf_valid),
        .bf_ready (bf_ready),
        .bf_idx_a (bf_idx_a),
        .bf_idx_b (bf_idx_b),
        .bf_zeta  (bf_zeta),
        .bf_slot  (bf_slot),
        .bf_last  (bf_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: cycleCnt is the index of the most recent rising edge
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Registered ROM with one cycle of read latency and no enable
    always @(posedge clk) rom_dout <= romMem[rom_addr];

    // Datapath ready: always 1, or a fair coin per cycle
    initial begin
        bf_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bf_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected command n of a pass: word n/2, low half first, last flag on the final one
    function automatic logic [29:0] modelCmd(input int n);
        logic [63:0] w;
        int          sh;
        w  = romMem[n / 2];
        sh = (n % 2) * 32;
        return {8'((w >> (sh + 8)) & 64'hff), 8'(w >> sh & 64'hff),
                12'((w >> (sh + 16)) & 64'hfff), 1'(n % 2), 1'(n == 2 * NUM_WORDS - 1)};
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_fmt_err"}, 64'(fmt_err), 64'd0);
        checkOutput({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        checkOutput({tag, "_bf_valid"}, 64'(bf_valid), 64'd0);
        checkOutput({tag, "_bf_cmd"}, 64'({bf_idx_a, bf_idx_b, bf_zeta, bf_slot, bf_last}), 64'd0);
    endtask

    // One pass: queue expectations, start, optionally pulse start / reset mid-pass, then check the end
    task automatic applyStimulus(input bit randReady, input bit pulseStarts, input int rstAtCmd);
        bit pulsed;
        int waitCnt;
        pulsed = 1'b0;
        expQ.delete();
        expFmt = 1'b0;
        for (int n = 0; n < 2 * NUM_WORDS; n++) expQ.push_back(modelCmd(n));
        for (int w = 0; w < NUM_WORDS; w++)
            if (romMem[w][63:60] != 4'h0 || romMem[w][31:28] != 4'h0) expFmt = 1'b1;
        readyRandom = randReady;
        checkOutput("fmt_err_before_start", 64'(fmt_err), 64'(prevFmt));
        start = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        e0Edge       = cycleCnt;
        rxCount      = 0;
        passStalls   = 0;
        lastFireEdge = -1;
        holdValid    = 1'b0;
        passActive   = 1'b1;
        checkOutput("busy_rise", 64'(busy), 64'd1);
        checkOutput("fmt_err_cleared", 64'(fmt_err), 64'd0);
        waitCnt = 0;
        while (!done && waitCnt < 3000) begin
            if (rstAtCmd > 0 && rxCount >= rstAtCmd) begin
                #2;
                passActive = 1'b0;
                rst_n      = 1'b0;
                #1;
                checkResetValues("midpass_reset");
                expQ.delete();
                repeat (2) @(posedge clk);
                #1;
                rst_n   = 1'b1;
                prevFmt = 1'b0;
                return;
            end
            if (pulseStarts && !pulsed && rxCount == 40) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            waitCnt++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", waitCnt);
            passActive = 1'b0;
            return;
        end
        checkOutput("done_edge", 64'(cycleCnt), 64'(lastFireEdge));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        checkOutput("fmt_err_at_done", 64'(fmt_err), 64'(expFmt));
        checkOutput("cmd_count", 64'(rxCount), 64'(2 * NUM_WORDS));
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        start = pulseStarts;
        @(posedge clk);
        #1;
        start = 1'b0;
        passActive = 1'b0;
        checkOutput("done_pulse_width", 64'(done), 64'd0);
        checkOutput("no_restart", 64'(busy), 64'd0);
        checkOutput("addr_idle", 64'(rom_addr), 64'd0);
        prevFmt = expFmt;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on each transfer, check timing and stall stability
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !passActive) begin
                checkOutput("idle_valid", 64'(bf_valid), 64'd0);
            end else if (rst_n && passActive) begin
                actCmd = {bf_idx_a, bf_idx_b, bf_zeta, bf_slot, bf_last};
                if (holdValid) begin
                    checkOutput("stall_hold", 64'({bf_valid, actCmd}), 64'({1'b1, heldCmd}));
                    holdValid = 1'b0;
                end
                if (bf_valid && bf_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL extra_cmd: got cmd 0x%0h, expected none", actCmd);
                    end else begin
                        expCmd = expQ.pop_front();
                        checkOutput($sformatf("cmd_%0d", rxCount), 64'(actCmd), 64'(expCmd));
                        checkOutput($sformatf("cmd_edge_%0d", rxCount), 64'(cycleCnt + 1),
                                    64'(e0Edge + 3 + rxCount + passStalls));
                        if (expCmd[0]) lastFireEdge = cycleCnt + 1;
                        rxCount++;
                    end
                end else if (bf_valid) begin
                    passStalls++;
                    holdValid = 1'b1;
                    heldCmd   = actCmd;
                end
            end
        end
    end

    initial begin
        logic [63:0] saved5;
        rst_n = 1'b0;
        start = 1'b0;
        romMem[0] = {4'h0, 12'h623, 8'h00, 8'h08, 4'h0, 12'h5d5, 8'h00, 8'h20};
        for (int w = 1; w < NUM_WORDS - 1; w++)
            romMem[w] = {$urandom, $urandom} & 64'h0fff_ffff_0fff_ffff;
        romMem[NUM_WORDS - 1] = {4'h0, 12'hac4, 8'hf7, 8'hff, 4'h0, 12'h0ca, 8'hdf, 8'hff};
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] pass 1: unstalled");
        applyStimulus(1'b0, 1'b0, 0);
        $display("[TB] pass 2: random back-pressure");
        applyStimulus(1'b1, 1'b0, 0);
        $display("[TB] pass 3: reserved bits in word 5");
        saved5    = romMem[5];
        romMem[5] = 64'h1000_0000_0000_0000;
        applyStimulus(1'b1, 1'b0, 0);
        romMem[5] = saved5;
        $display("[TB] pass 4: clean ROM again");
        applyStimulus(1'b0, 1'b0, 0);
        $display("[TB] pass 5: start pulses while busy and in done cycle");
        applyStimulus(1'b1, 1'b1, 0);
        $display("[TB] pass 6: reset at command 100");
        applyStimulus(1'b0, 1'b0, 100);
        $display("[TB] pass 7: restart after reset");
        applyStimulus(1'b0, 1'b0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
